// File: rtl/game_pkg.sv
// Shared types for the match sequencer: phase and winner encodings plus counter width.
package game_pkg;
    localparam int SEQ_CNT_W = 4;

    typedef enum logic [2:0] {
        ST_MENU      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_PLAY      = 3'd2,
        ST_PAUSE     = 3'd3,
        ST_RESULT    = 3'd4
    } game_state_t;

    typedef enum logic [1:0] {
        WIN_NONE    = 2'd0,
        WIN_PLAYERS = 2'd1,
        WIN_BOSS    = 2'd2
    } winner_t;
endpackage

// File: rtl/tick_prescaler.sv
// One-second tick generator; restarts its count whenever the sequencer changes phase.
module tick_prescaler #(
    parameter int TICK_DIV = 65_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || tick) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/match_sequencer.sv
// Round controller: menu -> countdown -> play <-> pause -> result, with world gating,
// entity re-init pulse and winner reporting.
module match_sequencer
    import game_pkg::*;
#(
    parameter int TICK_DIV      = 65_000_000,
    parameter int COUNTDOWN_S   = 3,
    parameter int RESULT_HOLD_S = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 p1_start,
    input  logic                 p2_start,
    input  logic                 p1_pause,
    input  logic                 p2_pause,
    input  logic [3:0]           p1_hp,
    input  logic [3:0]           p2_hp,
    input  logic [6:0]           boss_hp,
    output logic [2:0]           game_state,
    output logic [SEQ_CNT_W-1:0] countdown_val,
    output logic                 world_en,
    output logic                 entities_rst,
    output logic [1:0]           winner,
    output logic                 restart_ready
);
    game_state_t          state_q, state_d;
    winner_t              winner_q, winner_d;
    logic [SEQ_CNT_W-1:0] cd_q, cd_d;
    logic [SEQ_CNT_W-1:0] hold_q, hold_d;
    logic                 erst_q, erst_d;
    logic                 p1_pause_q, p2_pause_q;
    logic                 pause_edge, state_chg, tick;

    assign pause_edge = (p1_pause && !p1_pause_q) || (p2_pause && !p2_pause_q);

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_chg),
        .tick (tick)
    );

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        cd_d     = cd_q;
        hold_d   = hold_q;
        case (state_q)
            ST_MENU:
                if (p1_start && p2_start) state_d = ST_COUNTDOWN;
            ST_COUNTDOWN:
                if (tick) begin
                    cd_d = cd_q - SEQ_CNT_W'(1);
                    if (cd_q == SEQ_CNT_W'(1)) state_d = ST_PLAY;
                end
            ST_PLAY:
                // Boss death outranks a double KO, and any end condition outranks pause.
                if (boss_hp == 7'd0) begin
                    state_d  = ST_RESULT;
                    winner_d = WIN_PLAYERS;
                end else if (p1_hp == 4'd0 && p2_hp == 4'd0) begin
                    state_d  = ST_RESULT;
                    winner_d = WIN_BOSS;
                end else if (pause_edge) begin
                    state_d = ST_PAUSE;
                end
            ST_PAUSE:
                if (pause_edge) state_d = ST_PLAY;
            ST_RESULT: begin
                if (tick && hold_q != '0) hold_d = hold_q - SEQ_CNT_W'(1);
                if (restart_ready && (p1_start || p2_start)) state_d = ST_COUNTDOWN;
            end
            default: state_d = ST_MENU;
        endcase

        state_chg = (state_d != state_q);
        erst_d    = state_chg && (state_d == ST_COUNTDOWN);
        if (erst_d) begin
            cd_d     = SEQ_CNT_W'(COUNTDOWN_S);
            winner_d = WIN_NONE;
        end
        if (state_chg && state_d == ST_RESULT) hold_d = SEQ_CNT_W'(RESULT_HOLD_S);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_MENU;
            winner_q   <= WIN_NONE;
            cd_q       <= '0;
            hold_q     <= '0;
            erst_q     <= 1'b0;
            p1_pause_q <= 1'b0;
            p2_pause_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            winner_q   <= winner_d;
            cd_q       <= cd_d;
            hold_q     <= hold_d;
            erst_q     <= erst_d;
            p1_pause_q <= p1_pause;
            p2_pause_q <= p2_pause;
        end
    end

    assign game_state    = state_q;
    assign countdown_val = cd_q;
    assign world_en      = (state_q == ST_PLAY);
    assign entities_rst  = erst_q;
    assign winner        = winner_q;
    assign restart_ready = (state_q == ST_RESULT) && (hold_q == '0);
endmodule
